// File: rtl/mem_access_unit.sv
// Memory port between the multicycle control FSM and the unified instruction/data memory.
// Latency: request edge to done_o is 2 cycles minimum (ack in first req cycle), plus one per wait cycle.
// Backpressure: bus_req_o is held until bus_ack_i; busy_o stalls the FSM; no ack within TIMEOUT cycles gives a sticky error.
module mem_access_unit #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic              ir_write_i,
    input  logic              iord_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [ADDR_W-1:0] alu_out_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic              bus_ack_i,
    input  logic [DATA_W-1:0] bus_rdata_i,
    output logic [DATA_W-1:0] ir_o,
    output logic [3:0]        op_o,
    output logic [3:0]        funcf_o,
    output logic [DATA_W-1:0] mdr_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE,
        S_HOLD,
        S_ERR
    } state_t;

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic              we_q, we_d;
    logic              irw_q, irw_d;

    logic req_any;
    logic req_both;

    assign req_any  = mem_read_i | mem_write_i;
    assign req_both = mem_read_i & mem_write_i;

    // State and datapath registers; synchronous reset clears everything, so a
    // reset in the middle of an access simply abandons it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            ir_q    <= '0;
            mdr_q   <= '0;
            we_q    <= 1'b0;
            irw_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ir_q    <= ir_d;
            mdr_q   <= mdr_d;
            we_q    <= we_d;
            irw_q   <= irw_d;
        end
    end

    // Next-state logic: launch from IDLE, wait for ack or timeout in ACCESS,
    // then park in HOLD until the FSM drops its request level.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ir_d    = ir_q;
        mdr_d   = mdr_q;
        we_d    = we_q;
        irw_d   = irw_q;

        unique case (state_q)
            S_IDLE: begin
                if (req_both) begin
                    // Read and write together is a control FSM bug; refuse it.
                    state_d = S_ERR;
                end else if (req_any) begin
                    addr_d  = iord_i ? alu_out_i : pc_i;
                    wdata_d = wdata_i;
                    we_d    = mem_write_i;
                    irw_d   = ir_write_i;
                    cnt_d   = '0;
                    state_d = S_ACCESS;
                end
            end

            S_ACCESS: begin
                if (bus_ack_i) begin
                    // Read data is valid in the ack cycle; writes leave IR/MDR alone.
                    if (!we_q) begin
                        if (irw_q) begin
                            ir_d = bus_rdata_i;
                        end else begin
                            mdr_d = bus_rdata_i;
                        end
                    end
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    // This is the TIMEOUT-th cycle without an ack.
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_HOLD;
            end

            S_HOLD: begin
                // Wait for the request level to fall so one level gives one transaction.
                if (!req_any) begin
                    state_d = S_IDLE;
                end
            end

            S_ERR: begin
                state_d = S_ERR;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus and FSM-facing outputs decoded from state and latched transaction fields.
    always_comb begin
        bus_req_o   = (state_q == S_ACCESS);
        bus_we_o    = (state_q == S_ACCESS) & we_q;
        bus_addr_o  = addr_q;
        bus_wdata_o = wdata_q;
        done_o      = (state_q == S_DONE);
        err_o       = (state_q == S_ERR);
        busy_o      = ((state_q == S_IDLE) & req_any & ~req_both) | (state_q == S_ACCESS);
        ir_o        = ir_q;
        mdr_o       = mdr_q;
        op_o        = ir_q[DATA_W-1 -: 4];
        funcf_o     = ir_q[3:0];
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a scoreboard of expected transactions.
// Latency: checks exact cycle positions of req, done and timeout.
// Backpressure: the bench plays the memory, choosing when to ack.
module tb_mem_access_unit;

    logic        clk;
    logic        reset;
    logic        mem_read_i;
    logic        mem_write_i;
    logic        ir_write_i;
    logic        iord_i;
    logic [15:0] pc_i;
    logic [15:0] alu_out_i;
    logic [15:0] wdata_i;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [15:0] bus_addr_o;
    logic [15:0] bus_wdata_o;
    logic        bus_ack_i;
    logic [15:0] bus_rdata_i;
    logic [15:0] ir_o;
    logic [3:0]  op_o;
    logic [3:0]  funcf_o;
    logic [15:0] mdr_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] ir;
        logic [15:0] mdr;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    mem_access_unit #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(15)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_read_i (mem_read_i),
        .mem_write_i(mem_write_i),
        .ir_write_i (ir_write_i),
        .iord_i     (iord_i),
        .pc_i       (pc_i),
        .alu_out_i  (alu_out_i),
        .wdata_i    (wdata_i),
        .bus_req_o  (bus_req_o),
        .bus_we_o   (bus_we_o),
        .bus_addr_o (bus_addr_o),
        .bus_wdata_o(bus_wdata_o),
        .bus_ack_i  (bus_ack_i),
        .bus_rdata_i(bus_rdata_i),
        .ir_o       (ir_o),
        .op_o       (op_o),
        .funcf_o    (funcf_o),
        .mdr_o      (mdr_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction from IDLE: launch, ack after ack_cyc req cycles,
    // hold the level hold_cyc extra cycles, then release back to IDLE.
    task automatic txn(input logic wr, input logic irw, input logic iord,
                       input logic [15:0] pc, input logic [15:0] alu, input logic [15:0] wd,
                       input int ack_cyc, input logic [15:0] rdata,
                       input logic [15:0] exp_ir, input logic [15:0] exp_mdr,
                       input int hold_cyc);
        exp_t e;
        exp_t got;
        e.we    = wr;
        e.addr  = iord ? alu : pc;
        e.wdata = wd;
        e.ir    = exp_ir;
        e.mdr   = exp_mdr;
        sb.push_back(e);

        mem_read_i  = ~wr;
        mem_write_i = wr;
        ir_write_i  = irw;
        iord_i      = iord;
        pc_i        = pc;
        alu_out_i   = alu;
        wdata_i     = wd;
        #1;
        chk("busy_idle_req", busy_o, 1'b1);
        chk("req_before_edge", bus_req_o, 1'b0);
        step();

        // Scramble the sources: the bus must show the latched values.
        pc_i       = 16'hDEAD;
        alu_out_i  = 16'hDEAD;
        wdata_i    = 16'hDEAD;
        ir_write_i = ~irw;
        for (int i = 1; i <= ack_cyc; i++) begin
            chk("req_high", bus_req_o, 1'b1);
            chk("busy_access", busy_o, 1'b1);
            chk("bus_addr", bus_addr_o, sb[0].addr);
            chk("bus_we", bus_we_o, sb[0].we);
            chk("bus_wdata", bus_wdata_o, sb[0].wdata);
            chk("done_early", done_o, 1'b0);
            if (i == ack_cyc) begin
                bus_ack_i   = 1'b1;
                bus_rdata_i = rdata;
            end
            step();
        end
        bus_ack_i   = 1'b0;
        bus_rdata_i = 16'h0000;

        chk("done_pulse", done_o, 1'b1);
        chk("req_after_ack", bus_req_o, 1'b0);
        chk("busy_done", busy_o, 1'b0);
        if (sb.size() != 0) begin
            got = sb.pop_front();
            chk("ir_result", ir_o, got.ir);
            chk("mdr_result", mdr_o, got.mdr);
        end else begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end

        for (int h = 0; h < hold_cyc; h++) begin
            step();
            chk("hold_no_req", bus_req_o, 1'b0);
            chk("hold_not_busy", busy_o, 1'b0);
            chk("hold_no_done", done_o, 1'b0);
        end
        mem_read_i  = 1'b0;
        mem_write_i = 1'b0;
        step();
        chk("back_idle_req", bus_req_o, 1'b0);
        chk("back_idle_done", done_o, 1'b0);
    endtask

    initial begin
        int n_req;
        reset       = 1'b1;
        mem_read_i  = 1'b0;
        mem_write_i = 1'b0;
        ir_write_i  = 1'b0;
        iord_i      = 1'b0;
        pc_i        = 16'h0000;
        alu_out_i   = 16'h0000;
        wdata_i     = 16'h0000;
        bus_ack_i   = 1'b0;
        bus_rdata_i = 16'h0000;
        step();
        step();
        reset = 1'b0;

        // Reset values
        chk("rst_req", bus_req_o, 1'b0);
        chk("rst_we", bus_we_o, 1'b0);
        chk("rst_addr", bus_addr_o, 16'h0000);
        chk("rst_wdata", bus_wdata_o, 16'h0000);
        chk("rst_ir", ir_o, 16'h0000);
        chk("rst_mdr", mdr_o, 16'h0000);
        chk("rst_done", done_o, 1'b0);
        chk("rst_err", err_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);

        // Fetch: ack on third req cycle
        txn(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0999, 16'h0000, 3, 16'h8123, 16'h8123, 16'h0000, 1);
        chk("fetch_op", op_o, 4'h8);
        chk("fetch_funcf", funcf_o, 4'h3);

        // Load: immediate ack into MDR
        txn(1'b0, 1'b0, 1'b1, 16'h0011, 16'h0200, 16'h0000, 1, 16'hBEEF, 16'h8123, 16'hBEEF, 1);

        // Store: ack after one wait cycle; junk rdata must not land anywhere
        txn(1'b1, 1'b0, 1'b1, 16'h0012, 16'h0300, 16'h1234, 2, 16'h5555, 16'h8123, 16'hBEEF, 1);

        // Held read level across several cycles: a single transaction only
        txn(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000, 16'h0000, 1, 16'h1A2B, 16'h1A2B, 16'hBEEF, 3);
        chk("held_err", err_o, 1'b0);

        // Reset in the middle of an access, then a late ack
        mem_read_i = 1'b1;
        ir_write_i = 1'b1;
        iord_i     = 1'b0;
        pc_i       = 16'h0050;
        step();
        chk("rma_req_up", bus_req_o, 1'b1);
        reset      = 1'b1;
        mem_read_i = 1'b0;
        step();
        chk("rma_req_dropped", bus_req_o, 1'b0);
        reset       = 1'b0;
        bus_ack_i   = 1'b1;
        bus_rdata_i = 16'hFFFF;
        step();
        bus_ack_i   = 1'b0;
        bus_rdata_i = 16'h0000;
        chk("rma_ir", ir_o, 16'h0000);
        chk("rma_mdr", mdr_o, 16'h0000);
        chk("rma_done", done_o, 1'b0);
        chk("rma_req", bus_req_o, 1'b0);
        mem_read_i = 1'b1;
        #1;
        chk("rma_idle_busy", busy_o, 1'b1);
        mem_read_i = 1'b0;
        #1;

        // Normal fetch after the reset
        txn(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000, 16'h0000, 2, 16'h7654, 16'h7654, 16'h0000, 1);

        // Timeout: read with no ack
        mem_read_i = 1'b1;
        ir_write_i = 1'b0;
        iord_i     = 1'b1;
        alu_out_i  = 16'h0444;
        step();
        n_req = 0;
        for (int i = 0; i < 40; i++) begin
            if (!bus_req_o) break;
            n_req++;
            step();
        end
        chk("timeout_req_cycles", n_req, 15);
        chk("timeout_err", err_o, 1'b1);
        chk("timeout_busy", busy_o, 1'b0);
        chk("timeout_ir", ir_o, 16'h7654);
        chk("timeout_mdr", mdr_o, 16'h0000);
        mem_read_i = 1'b0;
        step();
        mem_write_i = 1'b1;
        #1;
        chk("err_busy_req", busy_o, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("err_no_req", bus_req_o, 1'b0);
            chk("err_sticky", err_o, 1'b1);
        end
        mem_write_i = 1'b0;

        // Reset, then read and write together
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst2_err", err_o, 1'b0);
        mem_read_i  = 1'b1;
        mem_write_i = 1'b1;
        #1;
        chk("both_busy", busy_o, 1'b0);
        step();
        chk("both_no_req", bus_req_o, 1'b0);
        chk("both_err", err_o, 1'b1);
        mem_read_i  = 1'b0;
        mem_write_i = 1'b0;
        step();
        chk("both_err_sticky", err_o, 1'b1);
        chk("both_still_no_req", bus_req_o, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
